fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 101 ++++++++++
 tb/tb_fetch_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer with redirect, decode handshake and memory timeout fault
module fetch_ctrl #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter int         MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       PC_sel,
    input  logic [7:0] Target,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    input  logic       mem_ack,
    input  logic [7:0] mem_data,
    output logic       instr_valid,
    output logic [7:0] instr,
    output logic [7:0] instr_pc,
    output logic [7:0] NPC,
    input  logic       dec_ready,
    output logic       fetch_err,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        HOLD = 2'b10,
        ERR  = 2'b11
    } state_t;

    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] instr_q, instr_d;
    logic [7:0] ipc_q, ipc_d;
    logic [7:0] wait_q, wait_d;

    // State and datapath registers; reset drops every output-driving state at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 8'h00;
            ipc_q   <= RESET_PC;
            wait_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            wait_q  <= wait_d;
        end
    end

    // Next state: redirect wins over ack/consume; ERR is terminal until reset
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                if (PC_sel) pc_d = Target;
                if (run) state_d = REQ;
            end
            REQ: begin
                if (PC_sel) begin
                    pc_d   = Target;
                    wait_d = 8'h00;
                end else if (mem_ack) begin
                    instr_d = mem_data;
                    ipc_d   = pc_q;
                    pc_d    = pc_q + 8'd1;
                    wait_d  = 8'h00;
                    state_d = HOLD;
                end else if (wait_q + 8'd1 == WAIT_LIM) begin
                    state_d = ERR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            HOLD: begin
                if (PC_sel) pc_d = Target;
                if (PC_sel || dec_ready) state_d = run ? REQ : IDLE;
            end
            default: ;
        endcase
    end

    assign mem_req     = state_q == REQ;
    assign instr_valid = state_q == HOLD;
    assign fetch_err   = state_q == ERR;
    assign state       = state_q;
    assign mem_addr    = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
    assign NPC         = ipc_q + 8'd1;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench for fetch_ctrl against a combinational addr^A5 memory
module tb_fetch_ctrl;

    logic       clk;
    logic       reset;
    logic       run;
    logic       PC_sel;
    logic [7:0] Target;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_data;
    logic       instr_valid;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic [7:0] NPC;
    logic       dec_ready;
    logic       fetch_err;
    logic [1:0] state;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] e;
    logic [7:0]  npc;
    logic [7:0]  mpc;
    int          n;

    fetch_ctrl dut (
        .clk(clk), .reset(reset), .run(run), .PC_sel(PC_sel), .Target(Target),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .NPC(NPC),
        .dec_ready(dec_ready), .fetch_err(fetch_err), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_data = mem_addr ^ 8'hA5;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; run = 1'b0; PC_sel = 1'b0; Target = 8'h00; mem_ack = 1'b1; dec_ready = 1'b0;
        mpc = 8'h00;
        tick(); tick();
        checks++;
        if ({state, mem_req, instr_valid, fetch_err} !== 5'b00000) begin
            errors++; $display("FAIL reset_ctrl got %b exp 00000", {state, mem_req, instr_valid, fetch_err});
        end
        checks++;
        if ({instr, instr_pc, NPC, mem_addr} !== 32'h00_00_01_00) begin
            errors++; $display("FAIL reset_data got %h exp 00000100", {instr, instr_pc, NPC, mem_addr});
        end
        reset = 1'b1;
        tick(); tick();
        checks++;
        if ({state, mem_req, instr_valid, mem_addr} !== {4'b0000, 8'h00}) begin
            errors++; $display("FAIL idle_ack_ignored got %h exp 000", {state, mem_req, instr_valid, mem_addr});
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_stream();
        run = 1'b1; mem_ack = 1'b1; dec_ready = 1'b1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++; $display("FAIL first_req_early got %b exp 0", mem_req);
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({mem_req, instr_valid, mem_addr} !== {2'b10, mpc}) begin
                errors++; $display("FAIL stream_req got %h exp %h", {mem_req, instr_valid, mem_addr}, {2'b10, mpc});
            end
            exp_q.push_back({mpc, mpc ^ 8'hA5});
            mpc = mpc + 8'd1;
            tick();
            if (exp_q.size() == 0) begin
                checks++; errors++; $display("FAIL stream_hold scoreboard empty");
            end else begin
                e = exp_q.pop_front(); npc = e[15:8] + 8'd1; checks++;
                if ({mem_req, instr_valid, instr_pc, instr, NPC} !== {2'b01, e, npc}) begin
                    errors++; $display("FAIL stream_hold got %h exp %h", {mem_req, instr_valid, instr_pc, instr, NPC}, {2'b01, e, npc});
                end
            end
            tick();
        end
    endtask

    task automatic test_redirect_req();
        PC_sel = 1'b1; Target = 8'h10; mem_ack = 1'b1;
        tick();
        checks++;
        if ({state, mem_req, instr_valid, mem_addr} !== {4'b0110, 8'h10}) begin
            errors++; $display("FAIL redirect_req got %h exp %h", {state, mem_req, instr_valid, mem_addr}, {4'b0110, 8'h10});
        end
        PC_sel = 1'b0; mpc = 8'h10;
        exp_q.push_back({mpc, mpc ^ 8'hA5});
        mpc = mpc + 8'd1;
        tick();
        if (exp_q.size() == 0) begin
            checks++; errors++; $display("FAIL redirect_req_hold scoreboard empty");
        end else begin
            e = exp_q.pop_front(); npc = e[15:8] + 8'd1; checks++;
            if ({state, instr_pc, instr, NPC} !== {2'b10, e, npc}) begin
                errors++; $display("FAIL redirect_req_hold got %h exp %h", {state, instr_pc, instr, NPC}, {2'b10, e, npc});
            end
        end
    endtask

    task automatic test_wrap();
        PC_sel = 1'b1; Target = 8'hFF; dec_ready = 1'b0;
        tick();
        checks++;
        if ({state, mem_addr} !== {2'b01, 8'hFF}) begin
            errors++; $display("FAIL wrap_redirect got %h exp 1ff", {state, mem_addr});
        end
        PC_sel = 1'b0; mpc = 8'hFF;
        exp_q.push_back({mpc, mpc ^ 8'hA5});
        mpc = mpc + 8'd1;
        tick();
        if (exp_q.size() == 0) begin
            checks++; errors++; $display("FAIL wrap_hold scoreboard empty");
        end else begin
            e = exp_q.pop_front(); npc = e[15:8] + 8'd1; checks++;
            if ({state, instr_pc, instr, NPC} !== {2'b10, e, npc}) begin
                errors++; $display("FAIL wrap_hold got %h exp %h", {state, instr_pc, instr, NPC}, {2'b10, e, npc});
            end
        end
        dec_ready = 1'b1;
        tick();
        checks++;
        if ({state, mem_addr} !== {2'b01, mpc}) begin
            errors++; $display("FAIL wrap_next_addr got %h exp %h", {state, mem_addr}, {2'b01, mpc});
        end
    endtask

    task automatic test_redirect_hold();
        dec_ready = 1'b0;
        exp_q.push_back({mpc, mpc ^ 8'hA5});
        mpc = mpc + 8'd1;
        tick();
        if (exp_q.size() == 0) begin
            checks++; errors++; $display("FAIL rh_hold scoreboard empty");
        end else begin
            e = exp_q.pop_front(); npc = e[15:8] + 8'd1; checks++;
            if ({state, instr_pc, instr, NPC} !== {2'b10, e, npc}) begin
                errors++; $display("FAIL rh_hold got %h exp %h", {state, instr_pc, instr, NPC}, {2'b10, e, npc});
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({state, instr_pc, instr} !== {2'b10, e}) begin
                errors++; $display("FAIL rh_stall got %h exp %h", {state, instr_pc, instr}, {2'b10, e});
            end
        end
        PC_sel = 1'b1; Target = 8'h40;
        tick();
        checks++;
        if ({instr_valid, mem_req, mem_addr} !== {2'b01, 8'h40}) begin
            errors++; $display("FAIL rh_flush got %h exp 140", {instr_valid, mem_req, mem_addr});
        end
        PC_sel = 1'b0; mpc = 8'h40;
        exp_q.push_back({mpc, mpc ^ 8'hA5});
        mpc = mpc + 8'd1;
        tick();
        if (exp_q.size() == 0) begin
            checks++; errors++; $display("FAIL rh_refetch scoreboard empty");
        end else begin
            e = exp_q.pop_front(); npc = e[15:8] + 8'd1; checks++;
            if ({state, instr_pc, instr, NPC} !== {2'b10, e, npc}) begin
                errors++; $display("FAIL rh_refetch got %h exp %h", {state, instr_pc, instr, NPC}, {2'b10, e, npc});
            end
        end
    endtask

    task automatic test_run_drop();
        dec_ready = 1'b1; mem_ack = 1'b0;
        tick();
        run = 1'b0; dec_ready = 1'b0;
        tick();
        checks++;
        if ({state, mem_req, mem_addr} !== {3'b011, mpc}) begin
            errors++; $display("FAIL run_drop_req got %h exp %h", {state, mem_req, mem_addr}, {3'b011, mpc});
        end
        mem_ack = 1'b1;
        exp_q.push_back({mpc, mpc ^ 8'hA5});
        mpc = mpc + 8'd1;
        tick();
        if (exp_q.size() == 0) begin
            checks++; errors++; $display("FAIL run_drop_hold scoreboard empty");
        end else begin
            e = exp_q.pop_front(); npc = e[15:8] + 8'd1; checks++;
            if ({state, instr_pc, instr, NPC} !== {2'b10, e, npc}) begin
                errors++; $display("FAIL run_drop_hold got %h exp %h", {state, instr_pc, instr, NPC}, {2'b10, e, npc});
            end
        end
        dec_ready = 1'b1;
        tick(); tick();
        checks++;
        if ({state, mem_req, instr_valid, mem_addr} !== {4'b0000, mpc}) begin
            errors++; $display("FAIL run_drop_idle got %h exp %h", {state, mem_req, instr_valid, mem_addr}, {4'b0000, mpc});
        end
        PC_sel = 1'b1; Target = 8'h77;
        tick();
        PC_sel = 1'b0; mem_ack = 1'b0;
        checks++;
        if ({state, mem_addr} !== {2'b00, 8'h77}) begin
            errors++; $display("FAIL idle_redirect got %h exp 077", {state, mem_addr});
        end
    endtask

    task automatic test_timeout();
        run = 1'b1; mem_ack = 1'b0; dec_ready = 1'b0;
        tick();
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 15) begin
            errors++; $display("FAIL timeout_cycles got %0d exp 15", n);
        end
        checks++;
        if ({state, fetch_err, mem_req, instr_valid} !== 5'b11100) begin
            errors++; $display("FAIL timeout_err got %b exp 11100", {state, fetch_err, mem_req, instr_valid});
        end
        PC_sel = 1'b1; Target = 8'h03; mem_ack = 1'b1; dec_ready = 1'b1;
        tick(); tick(); tick();
        checks++;
        if ({state, fetch_err, mem_req, instr_valid} !== 5'b11100) begin
            errors++; $display("FAIL err_sticky got %b exp 11100", {state, fetch_err, mem_req, instr_valid});
        end
        PC_sel = 1'b0; mem_ack = 1'b0; run = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({state, fetch_err, mem_addr} !== {3'b000, 8'h00}) begin
            errors++; $display("FAIL err_clear got %h exp 000", {state, fetch_err, mem_addr});
        end
        tick();
        reset = 1'b1;
    endtask

    task automatic test_async_reset();
        run = 1'b1; mem_ack = 1'b0; dec_ready = 1'b1;
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        checks++;
        if ({state, mem_addr} !== {2'b01, 8'h01}) begin
            errors++; $display("FAIL ar_setup got %h exp 101", {state, mem_addr});
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({mem_req, instr_valid, state, mem_addr, instr, instr_pc} !== {4'b0000, 24'h000000}) begin
            errors++; $display("FAIL ar_immediate got %h exp 0000000", {mem_req, instr_valid, state, mem_addr, instr, instr_pc});
        end
        #2;
        reset = 1'b1;
        tick();
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 8'h00}) begin
            errors++; $display("FAIL ar_restart got %h exp 100", {mem_req, mem_addr});
        end
        run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_redirect_req();
        test_wrap();
        test_redirect_hold();
        test_run_drop();
        test_timeout();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
